// File: rtl/mem_pkg.sv
// Shared types for the load/store sequencer: access size codes, FSM states and a
// byte-count helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StLdReq,
    StLdWait,
    StRmwRd,
    StRmwWait,
    StStWr,
    StResp
  } state_e;

  function automatic logic [3:0] bytes(size_e size);
    unique case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts and extends the top N bytes of a doubleword read,
// and merges N store bytes over the top of a doubleword read.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        is_signed,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merge_data
);

  always_comb begin
    load_data  = '0;
    merge_data = '0;
    unique case (size)
      SZ_B: begin
        load_data  = {{56{is_signed & rdata[63]}}, rdata[63:56]};
        merge_data = {wdata[7:0], rdata[55:0]};
      end
      SZ_H: begin
        load_data  = {{48{is_signed & rdata[63]}}, rdata[63:48]};
        merge_data = {wdata[15:0], rdata[47:0]};
      end
      SZ_W: begin
        load_data  = {{32{is_signed & rdata[63]}}, rdata[63:32]};
        merge_data = {wdata[31:0], rdata[31:0]};
      end
      SZ_D: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a big-endian 64-bit DataMemory: one request in flight,
// read-modify-write for sub-doubleword stores, one response per request.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_is_load,
  output logic        rsp_err,
  output logic [63:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  size_e       size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        err_q, err_d;
  logic [63:0] data_q, data_d;

  size_e       req_size_e;
  logic        fault;
  logic [63:0] load_ext;
  logic [63:0] merge_data;

  assign req_size_e = size_e'(req_size);
  // Unsigned 64-bit compare: huge addresses fault instead of wrapping.
  assign fault = ((req_addr[2:0] & 3'(bytes(req_size_e) - 4'd1)) != 3'd0) ||
                 (req_addr > 64'(MEM_BYTES - 8));

  mem_lane_align u_align (
    .size       (size_q),
    .is_signed  (sgn_q),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_ext),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    err_d     = err_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          size_d    = req_size_e;
          sgn_d     = req_signed;
          rd_d      = req_rd;
          is_load_d = req_is_load;
          err_d     = fault;
          data_d    = '0;
          if (fault)                   state_d = StResp;
          else if (req_is_load)        state_d = StLdReq;
          else if (req_size_e == SZ_D) state_d = StStWr;
          else                         state_d = StRmwRd;
        end
      end
      StLdReq:  state_d = StLdWait;
      StLdWait: begin
        data_d  = load_ext;
        state_d = StResp;
      end
      StRmwRd:  state_d = StRmwWait;
      StRmwWait: begin
        // Merged doubleword replaces the store data so ST_WR drives one register.
        wdata_d = merge_data;
        state_d = StStWr;
      end
      StStWr:   state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SZ_B;
      sgn_q     <= 1'b0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign mem_read    = (state_q == StLdReq) || (state_q == StRmwRd);
  assign mem_write   = (state_q == StStWr);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign rsp_data    = data_q;
  assign rsp_rd      = rd_q;
  assign rsp_is_load = is_load_q;
  assign rsp_err     = err_q;

endmodule
